fir_filter_v5: RTL and testbench
================================

FIR_FILTER_V5 -- requirements
Module: fir_filter_v5

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter N, default 16: tap count, N >= 2.
REQ-003 Parameter WIDTH, default 14: signed input sample width.
REQ-004 Parameter CW, default 16: signed coefficient width.
REQ-005 Parameter M, default 4: taps per partial-sum segment, 1 <= M <= N.
REQ-006 Parameter SHIFT, default 0: right-shift applied to the accumulator before output.
REQ-007 Parameter OUT_WIDTH, default 30: signed output width.
REQ-008 Parameter COEF_INIT, default the 16-tap symmetric set 112,243,618,1293,2217,3225,4089,4587 then mirrored (sum 32768): reset coefficients.
REQ-009 clk  in  1  rising-edge clock.
REQ-010 rst  in  1  asynchronous active-high reset.
REQ-011 din  in  WIDTH  signed sample.
REQ-012 din_valid  in  1  din is accepted on an edge where this is high.
REQ-013 coef_wr  in  1  writes coef_data to shadow[coef_addr].
REQ-014 coef_addr  in  clog2(N)  shadow tap index.
REQ-015 coef_data  in  CW  signed coefficient.
REQ-016 coef_commit  in  1  single-cycle pulse that copies shadow to active.
REQ-017 dout  out  OUT_WIDTH  signed filtered sample.
REQ-018 dout_valid  out  1  dout is new this cycle.
REQ-019 ovf  out  1  dout of this valid output was saturated.

Function
REQ-020 The delay line SHALL shift by one position only on edges where din_valid=1, with tap0 receiving din; it holds otherwise.
REQ-021 The pipeline SHALL have four stages: delay line, products, segment partial sums (ceil(N/M) segments), then the final sum registered with round/saturate applied.
REQ-022 A valid tag SHALL travel through the pipeline so that dout_valid=1 on exactly the 4th rising edge after each accepting edge (LATENCY=4), with one output per accepted sample.
REQ-023 The block SHALL have no backpressure: full throughput (din_valid=1 every cycle) is supported, and gaps in din_valid produce matching gaps in dout_valid.
REQ-024 Products SHALL be WIDTH+CW bits, and partial sums and the accumulator SHALL be ACC_W=WIDTH+CW+clog2(N) bits, with no internal overflow.
REQ-025 Output rounding SHALL be: if SHIFT>0, add 2^(SHIFT-1) to the accumulator, then arithmetic-shift right by SHIFT (round half up).
REQ-026 The rounded value SHALL saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], and ovf=1 with that output only when clipping occurred.
REQ-027 dout, dout_valid and ovf SHALL hold their values between outputs, except that dout_valid and ovf are 0 on cycles without a new output.
REQ-028 coef_wr SHALL affect only the shadow bank, and the active bank SHALL remain unchanged until coef_commit.
REQ-029 On coef_commit, all N active coefficients SHALL update on the same edge (never a partial set); products computed on later edges use the new set.
REQ-030 If coef_wr and coef_commit occur on the same edge, the commit SHALL copy the shadow contents from before that write, and the write lands in shadow.
REQ-031 coef_addr >= N SHALL be ignored.
REQ-032 When N is not a multiple of M, the final segment SHALL sum only the taps that exist.

Reset
REQ-033 While rst=1, the delay line, products, partial sums, valid tags, dout, dout_valid and ovf SHALL be 0.
REQ-034 While rst=1, both the active and shadow banks SHALL be set to COEF_INIT.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight samples, with no dout_valid pulses until 4 edges after the first accept following release.

Verification
REQ-036 Impulse: defaults, din=1 on one cycle then 0 with din_valid=1 throughout -> dout_valid 4 edges later, and dout sequence 112,243,618,1293,2217,3225,4089,4587,4587,...,112, then 0.
REQ-037 DC/rounding: SHIFT=15, OUT_WIDTH=16, din=100 continuous -> dout settles at 100 after N+4 edges with ovf=0; din=-8192 continuous -> -8192.
REQ-038 Saturation: SHIFT=0, OUT_WIDTH=16, din=8191 continuous -> dout=32767 with ovf=1; din=-8192 continuous -> dout=-32768 with ovf=1.
REQ-039 Coefficient swap: write shadow tap0=1 and others 0 while streaming, confirm outputs are unchanged before commit, then pulse commit -> dout equals din delayed by 4 accepted samples, with no mixed-set output after the transition.
REQ-040 Gapped input: din_valid pattern 1,0,0,1,1,0,1 for 200 cycles -> dout_valid count equals accept count, and values match a reference model.
REQ-041 Reset mid-stream: assert rst for 2 cycles during streaming -> all outputs 0 immediately, and the first dout_valid arrives 4 edges after the first accept following release, computed with COEF_INIT.

Source files
------------

// File: rtl/fir_filter_v5_if.sv
// rtl/fir_filter_v5_if.sv - sample, coefficient-update and output signals of the FIR filter
interface fir_filter_v5_if #(
  parameter int WIDTH     = 14,
  parameter int CW        = 16,
  parameter int AW        = 4,
  parameter int OUT_WIDTH = 30
);
  logic signed [WIDTH-1:0]     din;
  logic                        din_valid;
  logic                        coef_wr;
  logic        [AW-1:0]        coef_addr;
  logic signed [CW-1:0]        coef_data;
  logic                        coef_commit;
  logic signed [OUT_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        ovf;

  modport master (
    output din, din_valid, coef_wr, coef_addr, coef_data, coef_commit,
    input  dout, dout_valid, ovf
  );

  modport slave (
    input  din, din_valid, coef_wr, coef_addr, coef_data, coef_commit,
    output dout, dout_valid, ovf
  );
endinterface

// File: rtl/fir_filter_v5.sv
// rtl/fir_filter_v5.sv - pipelined FIR with segmented partial sums and shadow/active coefficient banks
module fir_filter_v5 #(
  parameter int N         = 16,
  parameter int WIDTH     = 14,
  parameter int CW        = 16,
  parameter int M         = 4,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 30,
  parameter logic [N*CW-1:0] COEF_INIT = {
    16'd112,  16'd243,  16'd618,  16'd1293, 16'd2217, 16'd3225, 16'd4089, 16'd4587,
    16'd4587, 16'd4089, 16'd3225, 16'd2217, 16'd1293, 16'd618,  16'd243,  16'd112}
) (
  input  logic           clk,
  input  logic           rst,
  fir_filter_v5_if.slave bus
);
  localparam int PW    = WIDTH + CW;
  localparam int ACC_W = PW + $clog2(N);
  localparam int RW    = ACC_W + 1;
  localparam int NSEG  = (N + M - 1) / M;

  localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] OMAX = {{(RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  logic signed [WIDTH-1:0]     dly_q    [N];
  logic signed [WIDTH-1:0]     dly_d    [N];
  logic signed [CW-1:0]        shadow_q [N];
  logic signed [CW-1:0]        shadow_d [N];
  logic signed [CW-1:0]        active_q [N];
  logic signed [CW-1:0]        active_d [N];
  logic signed [PW-1:0]        prod_q   [N];
  logic signed [PW-1:0]        prod_d   [N];
  logic signed [ACC_W-1:0]     psum_q   [NSEG];
  logic signed [ACC_W-1:0]     psum_d   [NSEG];
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic                        ovf_q, ovf_d;
  logic                        v_dly_q, v_dly_d, v_prod_q, v_prod_d;
  logic                        v_psum_q, v_psum_d, v_acc_q, v_acc_d;
  logic signed [RW-1:0]        rnd, shf;

  always_comb begin
    dly_d = dly_q;
    if (bus.din_valid) begin
      dly_d[0] = bus.din;
      for (int k = 1; k < N; k++) dly_d[k] = dly_q[k-1];
    end

    // Commit copies the shadow as it stood before any write landing on the same edge.
    active_d = active_q;
    shadow_d = shadow_q;
    if (bus.coef_commit) active_d = shadow_q;
    if (bus.coef_wr && (int'(bus.coef_addr) < N)) shadow_d[bus.coef_addr] = bus.coef_data;

    for (int k = 0; k < N; k++) prod_d[k] = dly_q[k] * active_q[k];

    for (int s = 0; s < NSEG; s++) begin
      psum_d[s] = '0;
      for (int j = 0; j < M; j++)
        if (s * M + j < N) psum_d[s] = psum_d[s] + ACC_W'(prod_q[s * M + j]);
    end

    acc_d = '0;
    for (int s = 0; s < NSEG; s++) acc_d = acc_d + psum_q[s];

    rnd = RW'(acc_q) + RND;
    shf = rnd >>> SHIFT;

    v_dly_d      = bus.din_valid;
    v_prod_d     = v_dly_q;
    v_psum_d     = v_prod_q;
    v_acc_d      = v_psum_q;
    dout_valid_d = v_acc_q;

    dout_d = dout_q;
    ovf_d  = 1'b0;
    if (v_acc_q) begin
      if (shf > OMAX) begin
        dout_d = OMAX[OUT_WIDTH-1:0];
        ovf_d  = 1'b1;
      end else if (shf < OMIN) begin
        dout_d = OMIN[OUT_WIDTH-1:0];
        ovf_d  = 1'b1;
      end else begin
        dout_d = shf[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        dly_q[k]    <= '0;
        prod_q[k]   <= '0;
        shadow_q[k] <= $signed(COEF_INIT[k*CW +: CW]);
        active_q[k] <= $signed(COEF_INIT[k*CW +: CW]);
      end
      for (int s = 0; s < NSEG; s++) psum_q[s] <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      v_dly_q      <= 1'b0;
      v_prod_q     <= 1'b0;
      v_psum_q     <= 1'b0;
      v_acc_q      <= 1'b0;
    end else begin
      dly_q        <= dly_d;
      prod_q       <= prod_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      psum_q       <= psum_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      v_dly_q      <= v_dly_d;
      v_prod_q     <= v_prod_d;
      v_psum_q     <= v_psum_d;
      v_acc_q      <= v_acc_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_fir_filter_v5.sv
// tb/tb_fir_filter_v5.sv - scoreboard bench driving default, rounding and saturating configurations in parallel
module tb_fir_filter_v5;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [13:0] din = '0;
  logic              din_valid = 1'b0;
  logic              coef_wr = 1'b0;
  logic        [3:0] coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic              coef_commit = 1'b0;

  fir_filter_v5_if #(.WIDTH(14), .CW(16), .AW(4), .OUT_WIDTH(30)) if_def ();
  fir_filter_v5_if #(.WIDTH(14), .CW(16), .AW(4), .OUT_WIDTH(16)) if_dc ();
  fir_filter_v5_if #(.WIDTH(14), .CW(16), .AW(4), .OUT_WIDTH(16)) if_sat ();

  assign {if_def.din, if_def.din_valid, if_def.coef_wr, if_def.coef_addr, if_def.coef_data, if_def.coef_commit} =
         {din, din_valid, coef_wr, coef_addr, coef_data, coef_commit};
  assign {if_dc.din, if_dc.din_valid, if_dc.coef_wr, if_dc.coef_addr, if_dc.coef_data, if_dc.coef_commit} =
         {din, din_valid, coef_wr, coef_addr, coef_data, coef_commit};
  assign {if_sat.din, if_sat.din_valid, if_sat.coef_wr, if_sat.coef_addr, if_sat.coef_data, if_sat.coef_commit} =
         {din, din_valid, coef_wr, coef_addr, coef_data, coef_commit};

  fir_filter_v5 u_def (.clk(clk), .rst(rst), .bus(if_def));
  fir_filter_v5 #(.SHIFT(15), .OUT_WIDTH(16)) u_dc (.clk(clk), .rst(rst), .bus(if_dc));
  fir_filter_v5 #(.SHIFT(0), .OUT_WIDTH(16)) u_sat (.clk(clk), .rst(rst), .bus(if_sat));

  typedef struct {
    longint acc;
    int     edge_n;
  } exp_t;

  exp_t   exp_q [3][$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     init_c [16] = '{112, 243, 618, 1293, 2217, 3225, 4089, 4587,
                          4587, 4089, 3225, 2217, 1293, 618, 243, 112};
  int     act [16];
  int     shd [16];
  longint hist [16];
  int     pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic int rd();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  function automatic void exp_out(input longint acc, input int sh, input int ow,
                                  output longint o, output bit ov);
    longint r, mx, mn;
    r = acc;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r  = r >>> sh;
    mx = (longint'(1) << (ow - 1)) - 1;
    mn = -mx - 1;
    ov = 1'b0;
    o  = r;
    if (r > mx) begin
      o  = mx;
      ov = 1'b1;
    end else if (r < mn) begin
      o  = mn;
      ov = 1'b1;
    end
  endfunction

  task automatic check(input int id, input string nm, input bit dv, input bit ov,
                       input longint d, input int sh, input int ow);
    exp_t   e;
    longint eo;
    bit     eov;
    if (dv) begin
      n_vec++;
      if (exp_q[id].size() == 0) begin
        n_err++;
        $display("FAIL %s unexpected output: dout=%0d, required no dout_valid", nm, d);
      end else begin
        e = exp_q[id].pop_front();
        exp_out(e.acc, sh, ow, eo, eov);
        if (d !== eo || ov !== eov || cyc - e.edge_n != 4) begin
          n_err++;
          $display("FAIL %s: dout=%0d ovf=%0b latency=%0d, required dout=%0d ovf=%0b latency=4",
                   nm, d, ov, cyc - e.edge_n, eo, eov);
        end
      end
    end else if (ov) begin
      n_err++;
      $display("FAIL %s ovf without dout_valid: ovf=1, required 0", nm);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check(0, "def", if_def.dout_valid, if_def.ovf, longint'(if_def.dout), 0, 30);
      check(1, "dc", if_dc.dout_valid, if_dc.ovf, longint'(if_dc.dout), 15, 16);
      check(2, "sat", if_sat.dout_valid, if_sat.ovf, longint'(if_sat.dout), 0, 16);
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      hist[k] = 0;
      act[k]  = init_c[k];
      shd[k]  = init_c[k];
    end
    for (int i = 0; i < 3; i++) exp_q[i].delete();
  endtask

  // Applies one cycle of inputs and advances the reference model by the matching clock edge.
  task automatic step(input int d, input bit v, input bit wr = 1'b0, input int addr = 0,
                      input int data = 0, input bit cm = 1'b0);
    exp_t e;
    din         = 14'(d);
    din_valid   = v;
    coef_wr     = wr;
    coef_addr   = 4'(addr);
    coef_data   = 16'(data);
    coef_commit = cm;
    if (cm) act = shd;
    if (wr) shd[addr] = data;
    if (v) begin
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      e.acc = 0;
      for (int k = 0; k < 16; k++) e.acc = e.acc + hist[k] * act[k];
      e.edge_n = cyc + 1;
      for (int i = 0; i < 3; i++) exp_q[i].push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    n_vec += 3;
    if ({if_def.dout, if_def.dout_valid, if_def.ovf} !== '0) begin
      n_err++;
      $display("FAIL %s def: dout=%0d dv=%0b ovf=%0b, required all 0", nm, if_def.dout, if_def.dout_valid, if_def.ovf);
    end
    if ({if_dc.dout, if_dc.dout_valid, if_dc.ovf} !== '0) begin
      n_err++;
      $display("FAIL %s dc: dout=%0d dv=%0b ovf=%0b, required all 0", nm, if_dc.dout, if_dc.dout_valid, if_dc.ovf);
    end
    if ({if_sat.dout, if_sat.dout_valid, if_sat.ovf} !== '0) begin
      n_err++;
      $display("FAIL %s sat: dout=%0d dv=%0b ovf=%0b, required all 0", nm, if_sat.dout, if_sat.dout_valid, if_sat.ovf);
    end
  endtask

  initial begin
    model_reset();
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // impulse response
    step(1, 1'b1);
    repeat (24) step(0, 1'b1);

    // DC levels and saturation extremes
    repeat (24) step(100, 1'b1);
    repeat (24) step(-8192, 1'b1);
    repeat (24) step(8191, 1'b1);
    repeat (24) step(-8192, 1'b1);

    repeat (60) step(rd(), 1'b1);

    // shadow writes while streaming, then commit a pass-through set
    for (int k = 0; k < 16; k++) step(rd(), 1'b1, 1'b1, k, (k == 0) ? 1 : 0);
    repeat (6) step(rd(), 1'b1);
    step(rd(), 1'b1, 1'b0, 0, 0, 1'b1);
    repeat (20) step(rd(), 1'b1);

    // write and commit on the same edge
    step(rd(), 1'b1, 1'b1, 1, 3);
    step(rd(), 1'b1, 1'b1, 0, 2, 1'b1);
    repeat (10) step(rd(), 1'b1);
    step(rd(), 1'b1, 1'b0, 0, 0, 1'b1);
    repeat (10) step(rd(), 1'b1);

    // random full-range coefficients, then gapped input
    for (int k = 0; k < 16; k++) step(rd(), 1'b1, 1'b1, k, int'($urandom_range(65535)) - 32768);
    step(rd(), 1'b1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 200; i++) step(rd(), pat[i % 7] != 0);

    // reset mid-stream
    repeat (10) step(rd(), 1'b1);
    din_valid = 1'b0;
    coef_wr   = 1'b0;
    rst       = 1'b1;
    model_reset();
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step(0, 1'b0);
    repeat (30) step(rd(), 1'b1);
    repeat (8) step(0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (exp_q[i].size() != 0) begin
        n_err++;
        $display("FAIL drain[%0d]: %0d outputs missing, required 0", i, exp_q[i].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
